// File: rtl/dtw_pe_array.sv
// Systolic linear array of NPE DTW cells streaming signal samples against a stored query.
// Optional best-match tracking is built when DTW_BEST_TRACK_EN is defined.
module dtw_pe_array #(
  parameter int SAMPLE_W = 8,
  parameter int WIDTH    = 18,
  parameter int NPE      = 8,
  parameter int IDX_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    cfg_subseq,
  input  logic                    q_we,
  input  logic [$clog2(NPE)-1:0]  q_addr,
  input  logic [SAMPLE_W-1:0]     q_data,
  input  logic                    s_valid,
  input  logic [SAMPLE_W-1:0]     s_data,
  output logic                    m_valid,
  output logic [WIDTH-1:0]        m_cost,
  output logic [IDX_W-1:0]        m_idx,
  output logic [WIDTH-1:0]        best_cost,
  output logic [IDX_W-1:0]        best_idx,
  output logic                    idle
);

  localparam int QA_W  = $clog2(NPE);
  localparam int SUM_W = ((WIDTH > SAMPLE_W) ? WIDTH : SAMPLE_W) + 1;
  localparam logic [WIDTH-1:0] INF     = '1;
  localparam logic [SUM_W-1:0] INF_EXT = {{(SUM_W-WIDTH){1'b0}}, INF};

  // Per-cell state; stage regs (v/s/idx) carry the token a cell processed last cycle.
  logic [SAMPLE_W-1:0] q_reg   [NPE];
  logic [WIDTH-1:0]    c_reg   [NPE];
  logic [WIDTH-1:0]    p_reg   [NPE];
  logic                v_reg   [NPE];
  logic [SAMPLE_W-1:0] s_reg   [NPE];
  logic [IDX_W-1:0]    idx_reg [NPE];

  logic                en      [NPE];
  logic [SAMPLE_W-1:0] s_in    [NPE];
  logic [IDX_W-1:0]    idx_in  [NPE];
  logic [WIDTH-1:0]    n_in    [NPE];
  logic [WIDTH-1:0]    nw_in   [NPE];
  logic [WIDTH-1:0]    c_next  [NPE];

  logic [IDX_W-1:0]    cnt_reg;
  logic                first_reg;
  logic                accept;
  logic                flush;
  logic                busy;

  assign accept = s_valid & ~clr;
  assign flush  = rst | clr;

  function automatic logic [WIDTH-1:0] min3(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic [WIDTH-1:0] c);
    logic [WIDTH-1:0] ab;
    ab = (a < b) ? a : b;
    return (ab < c) ? ab : c;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NPE; gi++) begin : g_cell
      logic [SAMPLE_W-1:0] d;
      logic [WIDTH-1:0]    m;
      logic [SUM_W-1:0]    sum;

      if (gi == 0) begin : g_head
        // Boundary row: subsequence mode lets a match start at any column.
        assign en[gi]     = accept;
        assign s_in[gi]   = s_data;
        assign idx_in[gi] = cnt_reg;
        assign n_in[gi]   = cfg_subseq ? '0 : INF;
        assign nw_in[gi]  = (cfg_subseq || first_reg) ? '0 : INF;
      end else begin : g_body
        assign en[gi]     = v_reg[gi-1];
        assign s_in[gi]   = s_reg[gi-1];
        assign idx_in[gi] = idx_reg[gi-1];
        assign n_in[gi]   = c_reg[gi-1];
        assign nw_in[gi]  = p_reg[gi-1];
      end

      always_comb begin
        d   = (s_in[gi] > q_reg[gi]) ? (s_in[gi] - q_reg[gi]) : (q_reg[gi] - s_in[gi]);
        m   = min3(n_in[gi], c_reg[gi], nw_in[gi]);
        sum = {{(SUM_W-SAMPLE_W){1'b0}}, d} + {{(SUM_W-WIDTH){1'b0}}, m};
        c_next[gi] = ((m == INF) || (sum >= INF_EXT)) ? INF : sum[WIDTH-1:0];
      end

      always_ff @(posedge clk) begin
        if (flush) begin
          c_reg[gi]   <= INF;
          p_reg[gi]   <= INF;
          v_reg[gi]   <= 1'b0;
          s_reg[gi]   <= '0;
          idx_reg[gi] <= '0;
        end else begin
          v_reg[gi] <= en[gi];
          if (en[gi]) begin
            c_reg[gi]   <= c_next[gi];
            p_reg[gi]   <= c_reg[gi];
            s_reg[gi]   <= s_in[gi];
            idx_reg[gi] <= idx_in[gi];
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          q_reg[gi] <= '0;
        end else if (q_we && (q_addr == QA_W'(gi))) begin
          q_reg[gi] <= q_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (flush) begin
      cnt_reg   <= '0;
      first_reg <= 1'b1;
    end else if (accept) begin
      cnt_reg   <= cnt_reg + IDX_W'(1);
      first_reg <= 1'b0;
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < NPE; i++) begin
      busy = busy | v_reg[i];
    end
  end

  assign idle    = ~busy;
  assign m_valid = v_reg[NPE-1];
  assign m_cost  = c_reg[NPE-1];
  assign m_idx   = idx_reg[NPE-1];

`ifdef DTW_BEST_TRACK_EN
  logic [WIDTH-1:0] best_cost_reg;
  logic [IDX_W-1:0] best_idx_reg;

  // Strict compare keeps the earliest column on ties.
  always_ff @(posedge clk) begin
    if (flush) begin
      best_cost_reg <= INF;
      best_idx_reg  <= '0;
    end else if (v_reg[NPE-1] && (c_reg[NPE-1] < best_cost_reg)) begin
      best_cost_reg <= c_reg[NPE-1];
      best_idx_reg  <= idx_reg[NPE-1];
    end
  end

  assign best_cost = best_cost_reg;
  assign best_idx  = best_idx_reg;
`else
  assign best_cost = INF;
  assign best_idx  = '0;
`endif

endmodule

// File: tb/tb_dtw_pe_array.sv
// Randomized bench for dtw_pe_array against a column-wise DTW reference model.
module tb_dtw_pe_array;
  localparam int SW  = 8;
  localparam int W   = 10;
  localparam int N   = 4;
  localparam int IW  = 4;
  localparam int INF = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          rst, clr, cfg_subseq, q_we, s_valid;
  logic [1:0]    q_addr;
  logic [SW-1:0] q_data, s_data;
  logic          m_valid, idle;
  logic [W-1:0]  m_cost, best_cost;
  logic [IW-1:0] m_idx, best_idx;

  dtw_pe_array #(.SAMPLE_W(SW), .WIDTH(W), .NPE(N), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .clr(clr), .cfg_subseq(cfg_subseq),
    .q_we(q_we), .q_addr(q_addr), .q_data(q_data),
    .s_valid(s_valid), .s_data(s_data),
    .m_valid(m_valid), .m_cost(m_cost), .m_idx(m_idx),
    .best_cost(best_cost), .best_idx(best_idx), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct { int due; int idx; int cost; } exp_t;
  exp_t expq[$];
  int   qm[N];
  int   prev_col[N];
  int   first_m, cnt_m, best_m, bidx_m, cyc;
  int   obs_cost[1 << IW];
  int   checks, errors;
  bit   chk_en, rst_pend;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset(input bit full);
    for (int i = 0; i < N; i++) begin
      prev_col[i] = INF;
      if (full) qm[i] = 0;
    end
    for (int i = 0; i < (1 << IW); i++) obs_cost[i] = -1;
    first_m = 1; cnt_m = 0; best_m = INF; bidx_m = 0;
    expq.delete();
  endtask

  // One DTW column: D[i][j] = |s-q[i]| + min(up, left, diag), saturating at INF.
  task automatic model_col(input int sd);
    int cur[N];
    int d, up, diag, left, mn;
    exp_t e;
    for (int i = 0; i < N; i++) begin
      d    = (sd > qm[i]) ? sd - qm[i] : qm[i] - sd;
      up   = (i == 0) ? (cfg_subseq ? 0 : INF) : cur[i-1];
      diag = (i == 0) ? ((cfg_subseq || first_m != 0) ? 0 : INF) : prev_col[i-1];
      left = prev_col[i];
      mn   = up;
      if (left < mn) mn = left;
      if (diag < mn) mn = diag;
      cur[i] = (mn >= INF || d + mn >= INF) ? INF : d + mn;
    end
    prev_col = cur;
    e.due = cyc + N; e.idx = cnt_m; e.cost = cur[N-1];
    expq.push_back(e);
    cnt_m = (cnt_m + 1) % (1 << IW);
    first_m = 0;
  endtask

  task automatic step(input bit sv, input int sd, input bit c, input bit r,
                      input bit we, input int qa, input int qd);
    bit   ev;
    exp_t e;
    @(negedge clk);
    cyc++;
    if (chk_en) begin
      if (rst_pend) begin
        check("rst_m_valid", m_valid, 0);
        check("rst_m_cost", m_cost, INF);
        check("rst_m_idx", m_idx, 0);
        check("rst_best_cost", best_cost, INF);
        check("rst_best_idx", best_idx, 0);
        check("rst_idle", idle, 1);
      end
      ev = (expq.size() > 0) && (expq[0].due == cyc);
      check("idle", idle, expq.size() == 0);
      check("m_valid", m_valid, ev);
`ifdef DTW_BEST_TRACK_EN
      check("best_cost", best_cost, best_m);
      check("best_idx", best_idx, bidx_m);
`else
      check("best_cost_tied", best_cost, INF);
      check("best_idx_tied", best_idx, 0);
`endif
      if (ev) begin
        e = expq.pop_front();
        if (m_valid) begin
          $display("result idx %0d cost %0d (expected idx %0d cost %0d)", m_idx, m_cost, e.idx, e.cost);
          check("m_idx", m_idx, e.idx);
          check("m_cost", m_cost, e.cost);
        end
        obs_cost[e.idx] = m_cost;
        if (e.cost < best_m) begin
          best_m = e.cost;
          bidx_m = e.idx;
        end
      end
    end
    rst_pend = r;
    s_valid = sv; s_data = SW'(sd); clr = c; rst = r;
    q_we = we; q_addr = 2'(qa); q_data = SW'(qd);
    if (r) begin
      model_reset(1);
    end else begin
      if (c) model_reset(0);
      else if (sv) model_col(sd);
      if (we && qa < N) qm[qa] = qd;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic load_query(input int a, input int b, input int c, input int d);
    step(0, 0, 0, 0, 1, 0, a);
    step(0, 0, 0, 0, 1, 1, b);
    step(0, 0, 0, 0, 1, 2, c);
    step(0, 0, 0, 0, 1, 3, d);
  endtask

  task automatic restart(input bit sub);
    step(0, 0, 1, 0, 0, 0, 0);
    cfg_subseq = sub;
  endtask

  initial begin
    int bubbles[9];
    int s;
    bubbles = '{1, 0, 0, 1, 0, 1, 1, 0, 1};
    checks = 0; errors = 0; cyc = 0; chk_en = 0; rst_pend = 0;
    rst = 1; clr = 0; cfg_subseq = 1; q_we = 0; q_addr = 0; q_data = 0;
    s_valid = 0; s_data = 0;
    model_reset(1);
    step(0, 0, 0, 1, 0, 0, 0);
    chk_en = 1;
    step(0, 0, 0, 1, 0, 0, 0);
    idle_cycles(1);

    // Subsequence match of 0..4 against {1,2,3,4}
    load_query(1, 2, 3, 4);
    for (int i = 0; i < 5; i++) step(1, i, 0, 0, 0, 0, 0);
    idle_cycles(N + 2);
    check("t1_idx4_cost", obs_cost[4], 0);

    // Global DTW over the same data
    restart(0);
    for (int i = 0; i < 5; i++) step(1, i, 0, 0, 0, 0, 0);
    idle_cycles(N + 2);
    check("t2_idx0_cost", obs_cost[0], 10);
    check("t2_idx4_cost", obs_cost[4], 1);

    // Bubbles between samples
    restart(1);
    s = 0;
    for (int i = 0; i < 9; i++) begin
      step(bubbles[i] != 0, s, 0, 0, 0, 0, 0);
      if (bubbles[i] != 0) s++;
    end
    idle_cycles(N + 2);
    check("t3_idx4_cost", obs_cost[4], 0);

    // Saturation: cost grows past 2^W-1 and must stick at INF
    restart(0);
    load_query(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 255, 0, 0, 0, 0, 0);
    idle_cycles(N + 2);
    check("sat_idx3_cost", obs_cost[3], 1020);
    check("sat_idx5_cost", obs_cost[5], INF);

    // clr with a concurrent sample mid-stream, then a clean restart
    restart(1);
    load_query(1, 2, 3, 4);
    for (int i = 0; i < 3; i++) step(1, i + 5, 0, 0, 0, 0, 0);
    step(1, 7, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, i, 0, 0, 0, 0, 0);
    idle_cycles(N + 2);
    check("clr_idx4_cost", obs_cost[4], 0);

    // Randomized rounds long enough to wrap the column index
    for (int r = 0; r < 12; r++) begin
      restart(1'($urandom_range(0, 1)));
      load_query($urandom_range(0, 15), $urandom_range(0, 15),
                 $urandom_range(0, 15), $urandom_range(0, 15));
      for (int i = 0; i < 30; i++) begin
        s = ($urandom_range(0, 9) == 0) ? 255 : $urandom_range(0, 15);
        step($urandom_range(0, 9) < 7, s, $urandom_range(0, 39) == 0, 0, 0, 0, 0);
      end
      idle_cycles(N + 2);
    end

    // Reset in the middle of a stream
    restart(1);
    load_query(3, 1, 4, 1);
    for (int i = 0; i < 6; i++) step(1, $urandom_range(0, 15), 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    idle_cycles(2);
    load_query(2, 7, 1, 8);
    for (int i = 0; i < 8; i++) step(1, $urandom_range(0, 15), 0, 0, 0, 0, 0);
    idle_cycles(N + 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
